// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one command at a time to a shared ALU, waits out its latency,
// captures the result (optionally into an accumulator) and returns it. Option: ALU_SEQ_OPCNT_EN.
module alu_op_sequencer #(
    parameter int ALU_LATENCY = 1,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    input  logic              cmd_wr_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] acc,
`ifdef ALU_SEQ_OPCNT_EN
    output logic [15:0]       op_count,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    state_t     state;
    logic [2:0] cnt;
    logic       wr_acc_q;

    // Handshake flags follow directly from the registered state.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Sequencer FSM: issue, wait out ALU latency, hold response until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_acc_q   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            acc        <= '0;
`ifdef ALU_SEQ_OPCNT_EN
            op_count   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_use_acc ? acc : cmd_b;
                        alu_opcode <= cmd_opcode;
                        wr_acc_q   <= cmd_wr_acc;
                        cnt        <= LAT;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        rsp_data  <= alu_result;
                        rsp_valid <= 1'b1;
                        if (wr_acc_q) begin
                            acc <= alu_result;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
`ifdef ALU_SEQ_OPCNT_EN
                        if (op_count != 16'hFFFF) begin
                            op_count <= op_count + 16'd1;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed steps with a result scoreboard; main DUT at latency 1,
// two extra instances at latency 0 and 3 for timing.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic       cmd_wr_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] acc;
    logic       busy;
`ifdef ALU_SEQ_OPCNT_EN
    logic [15:0] op_count;
    logic [15:0] sw_cnt [2];
`endif

    logic       sw_valid [2];
    logic       sw_cready[2];
    logic [7:0] sw_a     [2];
    logic [7:0] sw_b     [2];
    logic [3:0] sw_op    [2];
    logic [7:0] sw_res   [2];
    logic       sw_rv    [2];
    logic       sw_ready [2];
    logic [7:0] sw_rd    [2];
    logic [7:0] sw_acc   [2];
    logic       sw_busy  [2];

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_acc;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [3:0] exp_op;
    int         hs_count = 0;

    always #5 clk = ~clk;

    // Reference ALU: F = less-than, 0 = add, others xor.
    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [3:0] op);
        if (op == 4'hF) return (a < b) ? 8'h01 : 8'h00;
        if (op == 4'h0) return a + b;
        return a ^ b;
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_opcode);
    assign sw_res[0]  = alu_f(sw_a[0], sw_b[0], sw_op[0]);
    assign sw_res[1]  = alu_f(sw_a[1], sw_b[1], sw_op[1]);

    alu_op_sequencer #(.ALU_LATENCY(1), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .acc(acc),
`ifdef ALU_SEQ_OPCNT_EN
        .op_count(op_count),
`endif
        .busy(busy)
    );

    alu_op_sequencer #(.ALU_LATENCY(0), .DATA_W(8)) dut_l0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(sw_valid[0]), .cmd_ready(sw_cready[0]),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
        .alu_a(sw_a[0]), .alu_b(sw_b[0]), .alu_opcode(sw_op[0]),
        .alu_result(sw_res[0]),
        .rsp_valid(sw_rv[0]), .rsp_ready(sw_ready[0]), .rsp_data(sw_rd[0]),
        .acc(sw_acc[0]),
`ifdef ALU_SEQ_OPCNT_EN
        .op_count(sw_cnt[0]),
`endif
        .busy(sw_busy[0])
    );

    alu_op_sequencer #(.ALU_LATENCY(3), .DATA_W(8)) dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(sw_valid[1]), .cmd_ready(sw_cready[1]),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
        .alu_a(sw_a[1]), .alu_b(sw_b[1]), .alu_opcode(sw_op[1]),
        .alu_result(sw_res[1]),
        .rsp_valid(sw_rv[1]), .rsp_ready(sw_ready[1]), .rsp_data(sw_rd[1]),
        .acc(sw_acc[1]),
`ifdef ALU_SEQ_OPCNT_EN
        .op_count(sw_cnt[1]),
`endif
        .busy(sw_busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command on the main DUT and record the expected result.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic ua, input logic wa);
        int n;
        logic [7:0] e;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("issue_ready", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_a       = a;
        cmd_b       = b;
        cmd_opcode  = op;
        cmd_use_acc = ua;
        cmd_wr_acc  = wa;
        exp_a  = a;
        exp_b  = ua ? m_acc : b;
        exp_op = op;
        e = alu_f(exp_a, exp_b, op);
        exp_q.push_back(e);
        if (wa) m_acc = e;
        tick();
        cmd_valid = 1'b0;
        check("alu_a", alu_a, exp_a);
        check("alu_b", alu_b, exp_b);
        check("alu_opcode", alu_opcode, exp_op);
        check("busy", busy, 1);
        check("cmd_ready_low", cmd_ready, 0);
    endtask

    // Count edges after accept until rsp_valid; operands must hold meanwhile.
    task automatic wait_rsp(input int lat);
        int e;
        e = 0;
        while (!rsp_valid && e < 20) begin
            check("hold_a", alu_a, exp_a);
            check("hold_b", alu_b, exp_b);
            tick();
            e++;
        end
        check("rsp_latency", e, lat + 1);
        check("hold_a_rsp", alu_a, exp_a);
    endtask

    task automatic handshake();
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", rsp_data);
        end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        hs_count++;
        check("rsp_valid_drop", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        int e;
        int lat;
        logic [7:0] held;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_opcode  = '0;
        cmd_use_acc = 1'b0;
        cmd_wr_acc  = 1'b0;
        rsp_ready   = 1'b0;
        m_acc       = '0;
        for (int j = 0; j < 2; j++) begin
            sw_valid[j] = 1'b0;
            sw_ready[j] = 1'b0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 0);

        // Early rsp_ready must not disturb idle.
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("early_ready", rsp_valid, 0);

        // Less-than ops.
        issue(8'h02, 8'h19, 4'hF, 1'b0, 1'b0);
        wait_rsp(1);
        handshake();
        issue(8'h0A, 8'h05, 4'hF, 1'b0, 1'b0);
        wait_rsp(1);
        handshake();

        // Accumulator chain.
        issue(8'h05, 8'h03, 4'h0, 1'b0, 1'b1);
        wait_rsp(1);
        handshake();
        check("acc_op1", acc, 8'h08);
        issue(8'h01, 8'hEE, 4'h0, 1'b1, 1'b1);
        check("acc_to_b", alu_b, 8'h08);
        wait_rsp(1);
        handshake();
        check("acc_op2", acc, 8'h09);
        issue(8'h02, 8'h04, 4'h0, 1'b0, 1'b0);
        wait_rsp(1);
        handshake();
        check("acc_op3", acc, 8'h09);

        // Backpressure with a waiting command.
        issue(8'h33, 8'h44, 4'h0, 1'b0, 1'b0);
        wait_rsp(1);
        held        = rsp_data;
        cmd_valid   = 1'b1;
        cmd_a       = 8'h70;
        cmd_b       = 8'h07;
        cmd_opcode  = 4'h0;
        cmd_use_acc = 1'b0;
        cmd_wr_acc  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, held);
            check("bp_alu_a", alu_a, 8'h33);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        handshake();
        exp_a  = 8'h70;
        exp_b  = 8'h07;
        exp_op = 4'h0;
        exp_q.push_back(8'h77);
        tick();
        cmd_valid = 1'b0;
        check("bp_accept_a", alu_a, 8'h70);
        check("bp_accept_busy", busy, 1);
        wait_rsp(1);
        handshake();

`ifdef ALU_SEQ_OPCNT_EN
        check("op_count", op_count, hs_count);
`endif

        // Reset during WAIT of an accumulating op.
        issue(8'h10, 8'h20, 4'hF, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        m_acc = '0;
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_acc", acc, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_opcode", alu_opcode, 0);
        tick();
        tick();
        tick();
        check("mid_rst_no_rsp", rsp_valid, 0);
`ifdef ALU_SEQ_OPCNT_EN
        check("mid_rst_op_count", op_count, 0);
`endif

        // Latency sweep on the extra instances.
        for (int j = 0; j < 2; j++) begin
            lat         = (j == 0) ? 0 : 3;
            cmd_a       = 8'h21;
            cmd_b       = 8'h13;
            cmd_opcode  = 4'h0;
            cmd_use_acc = 1'b0;
            cmd_wr_acc  = 1'b1;
            sw_valid[j] = 1'b1;
            tick();
            sw_valid[j] = 1'b0;
            e = 0;
            while (!sw_rv[j] && e < 20) begin
                tick();
                e++;
            end
            check("sweep_latency", e, lat + 1);
            check("sweep_data", sw_rd[j], 8'h34);
            check("sweep_acc", sw_acc[j], 8'h34);
            sw_ready[j] = 1'b1;
            tick();
            sw_ready[j] = 1'b0;
            check("sweep_drop", sw_rv[j], 0);
        end

`ifdef ALU_SEQ_OPCNT_EN
        // Saturation of the op counter.
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        for (int i = 0; i < 2; i++) begin
            issue(8'h01, 8'h01, 4'h0, 1'b0, 1'b0);
            wait_rsp(1);
            handshake();
        end
        check("op_count_sat", op_count, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
